tl_finish_router: RTL
=====================

// Module: tl_finish_router
// PURPOSE
//  Routes one merged network stream (header src/dst + payload manager_xact_id) to one of
//  four destination ports, selected by header_dst. It is the fan-out counterpart of the
//  4:1 locking round-robin arbiter on the same stream.
//  Per-destination FIFOs stop a stalled destination from blocking traffic to the others.
// PARAMETERS
//  DEPTH   2  entries per destination FIFO; power of two, >= 2
//  XID_W   2  width of payload_manager_xact_id
// PORTS
//  clk                                   in   1      clock, all state on posedge
//  reset                                 in   1      asynchronous, active-high
//  io_in_ready                           out  1      input accepted this cycle when valid&ready
//  io_in_valid                           in   1      input beat present
//  io_in_bits_header_src                 in   2      source id, carried through unchanged
//  io_in_bits_header_dst                 in   2      destination select (0..3)
//  io_in_bits_payload_manager_xact_id    in   XID_W  transaction id, carried through unchanged
//  io_out_N_ready   (N=0..3)             in   1      destination N can take a beat
//  io_out_N_valid   (N=0..3)             out  1      FIFO N non-empty
//  io_out_N_bits_header_src/dst          out  2      head entry fields of FIFO N
//  io_out_N_bits_payload_manager_xact_id out  XID_W  head entry xact id of FIFO N
// BEHAVIOUR
//  - Reset (async assert, sync release): all FIFO write/read pointers and counts are 0.
//    All io_out_N_valid = 0 immediately. io_in_ready = 1 while reset is low.
//  - Per FIFO N: wptr, rptr (log2 DEPTH bits, wrap DEPTH-1 -> 0), count (log2 DEPTH + 1 bits).
//  - io_in_ready = ~full[io_in_bits_header_dst]. This is combinational from dst and does not depend on io_in_valid.
//  - Enqueue: io_in_valid & io_in_ready. The {src,dst,xid} entry is written at wptr[dst], then wptr++ and count++.
//  - Dequeue N: io_out_N_valid & io_out_N_ready. Then rptr[N]++ and count[N]--.
//  - io_out_N_valid = (count[N] != 0). Bits come straight from the storage at rptr[N].
//  - Latency: accept in cycle T, earliest io_out_dst_valid in cycle T+1. There is no bypass path.
//  - Full FIFO: not ready even if the same FIFO dequeues in that cycle. There is no pass-through.
//  - Same FIFO enqueues and dequeues in one cycle (not full, not empty): count unchanged, both pointers advance.
//  - Empty FIFO: valid stays 0. The bits outputs are don't-care.
//  - Ordering: per destination, FIFO order is strict. Ordering across destinations is not defined.
//  - Outputs are independent. A stall on N has no effect on ready for other dst values.
//  - Reset mid-operation: all buffered entries are discarded with no partial delivery.
//  - Storage is not reset. Only pointers and counts are reset.
// CONFIGURATION
//  TL_ROUTER_STATS_EN defined:
//   - Adds outputs io_stat_N_count (N=0..3, 8 bits each).
//   - io_stat_N_count increments on each dequeue of N and saturates at 8'hFF.
//   - Async reset to 0.
//  TL_ROUTER_STATS_EN undefined: these ports and counters do not exist. Routing behaviour is identical.
// TESTING (DEPTH=2, XID_W=2)
//  1 Reset asserted, then released -> all io_out_N_valid=0, io_in_ready=1. Repeat with reset asserted mid-cycle: outputs drop before the next edge.
//  2 One beat src=1 dst=2 xid=3, all out ready=0 -> next cycle only out_2_valid=1 with src=1 dst=2 xid=3.
//    Then out_2_ready=1 -> valid=0 the following cycle.
//  3 out_1_ready=0, two beats to dst=1 -> 3rd beat to dst=1 sees io_in_ready=0. A beat to dst=3 is accepted and appears on out_3.
//  4 FIFO 1 full, out_1_ready=1, in dst=1 valid -> io_in_ready=0 that cycle, =1 the next. Accepted beat appears after the two older entries.
//  5 Four beats dst=0 xid 0,1,2,3 with out_0_ready toggling 1,0,1,0 -> delivered xid 0,1,2,3 in order, none lost or duplicated.
//  6 (TL_ROUTER_STATS_EN) 300 dequeues on out_0 -> io_stat_0_count=255, other counts 0.
//    Reset -> all counts 0.

Source files
------------

// File: rtl/tl_finish_router.sv
// ---------------------------------------------------------------------------
// tl_finish_router
//
// Purpose:
//   Fans one merged network stream (header src/dst + payload manager_xact_id)
//   out to four destination ports, selected by io_in_bits_header_dst. Each
//   destination has its own small FIFO, so a stalled destination only blocks
//   beats addressed to itself; beats to the other destinations keep flowing.
//   This is the fan-out counterpart of the 4:1 locking round-robin arbiter
//   that merges the same stream.
//
// Parameters:
//   DEPTH  entries per destination FIFO (power of two, >= 2)
//   XID_W  width of payload_manager_xact_id
//
// Ports:
//   clk, reset                            clock; asynchronous active-high reset
//   io_in_valid / io_in_ready             input handshake (ready = FIFO[dst] not full)
//   io_in_bits_header_src/dst             2-bit source id / destination select
//   io_in_bits_payload_manager_xact_id    XID_W transaction id
//   io_out_N_valid / io_out_N_ready       per-destination handshake, N = 0..3
//   io_out_N_bits_*                       head entry of FIFO N
//   io_stat_N_count                       8-bit saturating dequeue counters
//                                         (only when TL_ROUTER_STATS_EN is defined)
//
// Configuration:
//   TL_ROUTER_STATS_EN  define to add the per-destination dequeue counters.
//                       Routing behaviour is the same with or without it.
//
// Timing notes:
//   A beat accepted in cycle T is visible at its output no earlier than T+1;
//   there is no bypass from input to output. A full FIFO refuses input even
//   when it is being drained in the same cycle, which keeps io_in_ready a
//   function of registered state and dst only (no path from io_out_N_ready).
// ---------------------------------------------------------------------------
module tl_finish_router #(
  parameter int DEPTH = 2,
  parameter int XID_W = 2
) (
  input  logic             clk,
  input  logic             reset,

  output logic             io_in_ready,
  input  logic             io_in_valid,
  input  logic [1:0]       io_in_bits_header_src,
  input  logic [1:0]       io_in_bits_header_dst,
  input  logic [XID_W-1:0] io_in_bits_payload_manager_xact_id,

  input  logic             io_out_0_ready,
  output logic             io_out_0_valid,
  output logic [1:0]       io_out_0_bits_header_src,
  output logic [1:0]       io_out_0_bits_header_dst,
  output logic [XID_W-1:0] io_out_0_bits_payload_manager_xact_id,

  input  logic             io_out_1_ready,
  output logic             io_out_1_valid,
  output logic [1:0]       io_out_1_bits_header_src,
  output logic [1:0]       io_out_1_bits_header_dst,
  output logic [XID_W-1:0] io_out_1_bits_payload_manager_xact_id,

  input  logic             io_out_2_ready,
  output logic             io_out_2_valid,
  output logic [1:0]       io_out_2_bits_header_src,
  output logic [1:0]       io_out_2_bits_header_dst,
  output logic [XID_W-1:0] io_out_2_bits_payload_manager_xact_id,

  input  logic             io_out_3_ready,
  output logic             io_out_3_valid,
  output logic [1:0]       io_out_3_bits_header_src,
  output logic [1:0]       io_out_3_bits_header_dst,
  output logic [XID_W-1:0] io_out_3_bits_payload_manager_xact_id
`ifdef TL_ROUTER_STATS_EN
  ,
  output logic [7:0]       io_stat_0_count,
  output logic [7:0]       io_stat_1_count,
  output logic [7:0]       io_stat_2_count,
  output logic [7:0]       io_stat_3_count
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  // Stored entry layout: {src[1:0], dst[1:0], xid[XID_W-1:0]}
  localparam int ENT_W = 4 + XID_W;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [ENT_W-1:0]      in_entry;
  logic [3:0]            out_ready;
  logic [3:0]            out_valid;
  logic [3:0]            fifo_full;
  logic [3:0]            enq;
  logic [3:0]            deq;
  logic [3:0][ENT_W-1:0] head;

  assign in_entry  = {io_in_bits_header_src, io_in_bits_header_dst,
                      io_in_bits_payload_manager_xact_id};
  assign out_ready = {io_out_3_ready, io_out_2_ready, io_out_1_ready, io_out_0_ready};

  // Ready is looked up by the offered dst, independent of io_in_valid, so an
  // upstream arbiter can see back-pressure before committing to a beat.
  assign io_in_ready = ~fifo_full[io_in_bits_header_dst];

  // -------------------------------------------------------------------------
  // One FIFO per destination
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_fifo
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    // Payload storage; deliberately not reset, only the pointers/counts are.
    logic [ENT_W-1:0] mem_q [DEPTH];

    assign fifo_full[gi] = (count_q == FULL_CNT);
    assign out_valid[gi] = (count_q != '0);
    assign enq[gi]       = io_in_valid & io_in_ready & (io_in_bits_header_dst == 2'(gi));
    assign deq[gi]       = out_valid[gi] & out_ready[gi];

    always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;

      if (enq[gi]) begin
        wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
      end
      if (deq[gi]) begin
        rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
      end

      // Simultaneous enqueue and dequeue leaves the occupancy unchanged.
      unique case ({enq[gi], deq[gi]})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
      end else begin
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
        count_q <= count_d;
      end
    end

    always_ff @(posedge clk) begin
      if (enq[gi]) begin
        mem_q[wptr_q] <= in_entry;
      end
    end

    // Head entry is read straight from storage; meaningless while empty.
    assign head[gi] = mem_q[rptr_q];
  end

  // -------------------------------------------------------------------------
  // Output port mapping
  // -------------------------------------------------------------------------
  assign io_out_0_valid                        = out_valid[0];
  assign io_out_0_bits_header_src              = head[0][ENT_W-1 -: 2];
  assign io_out_0_bits_header_dst              = head[0][ENT_W-3 -: 2];
  assign io_out_0_bits_payload_manager_xact_id = head[0][XID_W-1:0];

  assign io_out_1_valid                        = out_valid[1];
  assign io_out_1_bits_header_src              = head[1][ENT_W-1 -: 2];
  assign io_out_1_bits_header_dst              = head[1][ENT_W-3 -: 2];
  assign io_out_1_bits_payload_manager_xact_id = head[1][XID_W-1:0];

  assign io_out_2_valid                        = out_valid[2];
  assign io_out_2_bits_header_src              = head[2][ENT_W-1 -: 2];
  assign io_out_2_bits_header_dst              = head[2][ENT_W-3 -: 2];
  assign io_out_2_bits_payload_manager_xact_id = head[2][XID_W-1:0];

  assign io_out_3_valid                        = out_valid[3];
  assign io_out_3_bits_header_src              = head[3][ENT_W-1 -: 2];
  assign io_out_3_bits_header_dst              = head[3][ENT_W-3 -: 2];
  assign io_out_3_bits_payload_manager_xact_id = head[3][XID_W-1:0];

`ifdef TL_ROUTER_STATS_EN
  // -------------------------------------------------------------------------
  // Per-destination dequeue counters, saturating at 8'hFF
  // -------------------------------------------------------------------------
  logic [3:0][7:0] stat_count;

  for (genvar gi = 0; gi < 4; gi++) begin : g_stat
    logic [7:0] stat_q, stat_d;

    always_comb begin
      stat_d = stat_q;
      if (deq[gi] && (stat_q != 8'hFF)) begin
        stat_d = stat_q + 8'd1;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stat_q <= '0;
      end else begin
        stat_q <= stat_d;
      end
    end

    assign stat_count[gi] = stat_q;
  end

  assign io_stat_0_count = stat_count[0];
  assign io_stat_1_count = stat_count[1];
  assign io_stat_2_count = stat_count[2];
  assign io_stat_3_count = stat_count[3];
`endif

endmodule
